// File: rtl/param_mem_array.sv
// param_mem_array: parametrised single-port word memory with registered read,
// read-during-write selection, a hardware clear sweep and out-of-range detection.
// Valid configurations satisfy 2 <= DEPTH <= 2**ADDR_W.
module param_mem_array #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 6,
    parameter int unsigned       DEPTH     = 64,
    parameter int unsigned       RDW_MODE  = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr_req,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              busy,
    output logic              clr_done,
    output logic              addr_err
);

    // One extra bit so DEPTH = 2**ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
    // Sweep terminates on this compare, never on counter wrap.
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_valid_q, rd_valid_d;
    logic                clr_done_q, clr_done_d;
    logic                addr_err_q, addr_err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                in_range;
    logic                accept;
    logic                wr_fire;
    logic                rd_fire;
    logic                sweep_we;

    // Access qualification, FSM next state and registered read path.
    always_comb begin
        in_range   = ({1'b0, addr} < DepthW);
        // clr_req wins over a concurrent access; nothing is accepted while sweeping.
        accept     = (state_q == StIdle) && !clr_req;
        wr_fire    = accept && wr_en && in_range;
        rd_fire    = accept && rd_en && in_range;
        state_d    = state_q;
        cnt_d      = cnt_q;
        sweep_we   = 1'b0;
        clr_done_d = 1'b0;
        rd_valid_d = 1'b0;
        rdata_d    = rdata_q;
        addr_err_d = accept && (rd_en || wr_en) && !in_range;

        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                sweep_we = 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (rd_fire) begin
            rd_valid_d = 1'b1;
            // Shared address: a concurrent write always targets the read address.
            if ((RDW_MODE != 0) && wr_fire) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem_q[addr];
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            clr_done_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            clr_done_q <= clr_done_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage: not reset; a reset edge suppresses any write so an aborted sweep stops cleanly.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (sweep_we) begin
                mem_q[cnt_q] <= CLEAR_VAL;
            end else if (wr_fire) begin
                mem_q[addr] <= wdata;
            end
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == StClear);
    assign clr_done = clr_done_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_param_mem_array.sv
// Testbench for param_mem_array: three 8-bit instances share stimulus
// (old-data RDW, write-through RDW, DEPTH=48) and a 16x256 instance runs alone.
module tb_param_mem_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr, rd, clr;
    logic [5:0]  addr;
    logic [7:0]  wdata;

    logic [7:0]  a_rdata, b_rdata, c_rdata;
    logic        a_valid, a_busy, a_done, a_err;
    logic        b_valid, b_busy, b_done, b_err;
    logic        c_valid, c_busy, c_done, c_err;

    logic        w_wr, w_rd, w_clr;
    logic [7:0]  w_addr;
    logic [15:0] w_wdata, w_rdata;
    logic        w_valid, w_busy, w_done, w_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    param_mem_array #(.RDW_MODE(0)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .wr_en(wr), .rd_en(rd), .addr(addr), .wdata(wdata),
        .clr_req(clr), .rdata(a_rdata), .rd_valid(a_valid), .busy(a_busy), .clr_done(a_done),
        .addr_err(a_err)
    );

    param_mem_array #(.RDW_MODE(1)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .wr_en(wr), .rd_en(rd), .addr(addr), .wdata(wdata),
        .clr_req(clr), .rdata(b_rdata), .rd_valid(b_valid), .busy(b_busy), .clr_done(b_done),
        .addr_err(b_err)
    );

    param_mem_array #(.DEPTH(48)) dut_c (
        .wb_clk_i(clk), .wb_rst_i(rst), .wr_en(wr), .rd_en(rd), .addr(addr), .wdata(wdata),
        .clr_req(clr), .rdata(c_rdata), .rd_valid(c_valid), .busy(c_busy), .clr_done(c_done),
        .addr_err(c_err)
    );

    param_mem_array #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut_w (
        .wb_clk_i(clk), .wb_rst_i(rst), .wr_en(w_wr), .rd_en(w_rd), .addr(w_addr),
        .wdata(w_wdata), .clr_req(w_clr), .rdata(w_rdata), .rd_valid(w_valid), .busy(w_busy),
        .clr_done(w_done), .addr_err(w_err)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic       exp_valid;
        logic       chk_rd;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive shared inputs, take one edge, sample 1 time unit later.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [5:0] ad,
                       input logic [7:0] d);
        wr = w; rd = r; clr = c; addr = ad; wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wcyc(input logic w, input logic r, input logic [7:0] ad, input logic [15:0] d);
        w_wr = w; w_rd = r; w_addr = ad; w_wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_a, busy_c, done_a, done_c, valid_sweep;
        vecs[0] = '{1'b1, 1'b0, 6'h39, 8'hFA, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 6'h18, 8'hEA, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 6'h39, 8'h00, 1'b1, 1'b1, 8'hFA};
        vecs[3] = '{1'b0, 1'b1, 6'h18, 8'h00, 1'b1, 1'b1, 8'hEA};
        vecs[4] = '{1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b1, 8'hEA};
        vecs[5] = '{1'b1, 1'b0, 6'h10, 8'h55, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 6'h00, 8'h12, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 1'b1, 6'h00, 8'h00, 1'b1, 1'b1, 8'h12};
        vecs[8] = '{1'b1, 1'b0, 6'h3F, 8'h34, 1'b0, 1'b0, 8'h00};
        vecs[9] = '{1'b0, 1'b1, 6'h3F, 8'h00, 1'b1, 1'b1, 8'h34};

        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; addr = '0; wdata = '0;
        w_wr = 1'b0; w_rd = 1'b0; w_clr = 1'b0; w_addr = '0; w_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_rdata", 32'(a_rdata), 32'h0);
        chk("rst_a_flags", {a_valid, a_busy, a_done, a_err}, 32'h0);
        chk("rst_c_flags", {c_rdata, c_valid, c_busy, c_done, c_err}, 32'h0);
        chk("rst_w_flags", {w_rdata, w_valid, w_busy, w_done, w_err}, 32'h0);
        rst = 1'b0;

        // Basic write/read vectors.
        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].wr, vecs[i].rd, 1'b0, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("tbl%0d_valid", i), 32'(a_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("tbl%0d_err", i), 32'(a_err), 32'h0);
            if (vecs[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), 32'(a_rdata),
                                    32'(vecs[i].exp_rdata));
        end

        // Read-during-write on 0x10 (holds 0x55).
        cyc(1'b1, 1'b1, 1'b0, 6'h10, 8'hAA);
        chk("rdw_old_a", {a_valid, a_rdata}, {1'b1, 8'h55});
        chk("rdw_new_b", {b_valid, b_rdata}, {1'b1, 8'hAA});
        cyc(1'b0, 1'b1, 1'b0, 6'h10, 8'h00);
        chk("rdw_after_a", 32'(a_rdata), 32'hAA);
        chk("rdw_after_b", 32'(b_rdata), 32'hAA);

        // Clear sweep; the concurrent read is dropped.
        cyc(1'b0, 1'b1, 1'b1, 6'h39, 8'h00);
        chk("clr_drop", {a_valid, a_err, a_busy}, 32'b001);
        busy_a = 0; busy_c = 0; done_a = 0; done_c = 0; valid_sweep = 0;
        for (int i = 0; i < 80; i++) begin
            busy_a += int'(a_busy);
            busy_c += int'(c_busy);
            done_a += int'(a_done);
            done_c += int'(c_done);
            valid_sweep += int'(a_valid && a_busy) + int'(a_err);
            if (i == 20) cyc(1'b1, 1'b1, 1'b0, 6'h05, 8'h99);
            else if (i == 30) cyc(1'b0, 1'b0, 1'b1, 6'h00, 8'h00);
            else cyc(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        end
        chk("clr_busy_a", busy_a, 64);
        chk("clr_busy_c", busy_c, 48);
        chk("clr_done_a", done_a, 1);
        chk("clr_done_c", done_c, 1);
        chk("clr_ignored", valid_sweep, 0);
        cyc(1'b0, 1'b1, 1'b0, 6'h00, 8'h00);
        chk("clr_rd00_a", {a_valid, a_rdata}, {1'b1, 8'h00});
        chk("clr_rd00_c", {c_valid, c_rdata}, {1'b1, 8'h00});
        cyc(1'b0, 1'b1, 1'b0, 6'h3F, 8'h00);
        chk("clr_rd3f_a", {a_valid, a_rdata}, {1'b1, 8'h00});
        cyc(1'b0, 1'b1, 1'b0, 6'h05, 8'h00);
        chk("clr_rd05_a", {a_valid, a_rdata}, {1'b1, 8'h00});

        // Range error on the DEPTH=48 instance.
        cyc(1'b1, 1'b0, 1'b0, 6'h2F, 8'h5A);
        chk("rng_wr2f_err", 32'(c_err), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 6'h2F, 8'h00);
        chk("rng_rd2f", {c_valid, c_rdata}, {1'b1, 8'h5A});
        cyc(1'b1, 1'b0, 1'b0, 6'h30, 8'h77);
        chk("rng_wr30_err", {c_err, a_err}, 32'b10);
        cyc(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        chk("rng_err_pulse", 32'(c_err), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 6'h30, 8'h00);
        chk("rng_rd30_c", {c_err, c_valid, c_rdata}, {2'b10, 8'h5A});
        chk("rng_rd30_a", {a_err, a_valid, a_rdata}, {2'b01, 8'h77});
        cyc(1'b0, 1'b1, 1'b0, 6'h2F, 8'h00);
        chk("rng_rd2f_again", {c_valid, c_rdata}, {1'b1, 8'h5A});

        // Reset during a sweep.
        cyc(1'b1, 1'b0, 1'b0, 6'h3E, 8'hC3);
        cyc(1'b1, 1'b0, 1'b0, 6'h05, 8'h5E);
        cyc(1'b0, 1'b0, 1'b1, 6'h00, 8'h00);
        repeat (10) cyc(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        chk("mid_busy_before", 32'(a_busy), 32'h1);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        chk("mid_rst_state", {a_busy, a_done, a_valid, a_rdata}, 32'h0);
        rst = 1'b0;
        done_a = 0;
        for (int i = 0; i < 70; i++) begin
            done_a += int'(a_done) + int'(a_busy);
            cyc(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        end
        chk("mid_no_done", done_a, 0);
        cyc(1'b0, 1'b1, 1'b0, 6'h3E, 8'h00);
        chk("mid_rd3e_a", {a_valid, a_rdata}, {1'b1, 8'hC3});
        chk("mid_rd3e_c_err", 32'(c_err), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 6'h05, 8'h00);
        chk("mid_rd05_a", {a_valid, a_rdata}, {1'b1, 8'h00});
        chk("mid_rd05_c", {c_valid, c_rdata}, {1'b1, 8'h00});
        cyc(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);

        // 16x256 instance: fill and read back every entry.
        for (int i = 0; i < 256; i++) begin
            wcyc(1'b1, 1'b0, 8'(i), 16'hA5A5 ^ 16'(i));
        end
        for (int i = 0; i < 256; i++) begin
            wcyc(1'b0, 1'b1, 8'(i), 16'h0000);
            chk($sformatf("wide_rd%0d", i), {w_err, w_valid, w_rdata},
                {2'b01, 16'hA5A5 ^ 16'(i)});
        end
        wcyc(1'b0, 1'b0, 8'h00, 16'h0000);
        chk("wide_idle_valid", {w_valid, w_rdata}, {1'b0, 16'hA5A5 ^ 16'h00FF});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
